// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP poller: sensor addresses,
// the sweep address table, sample width and the DRP access FSM encoding.
package xadc_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 16;
  localparam int SAMPLE_W  = 12;
  localparam int SWEEP_LEN = 4;

  localparam logic [ADDR_W-1:0] ADDR_TEMP   = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_VCCINT = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_VCCAUX = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_VBRAM  = 7'h06;

  typedef logic [1:0] sweep_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Sweep order: temperature first, then the three supply rails.
  function automatic logic [ADDR_W-1:0] sweep_addr(input sweep_idx_t idx);
    case (idx)
      2'd0:    return ADDR_TEMP;
      2'd1:    return ADDR_VCCINT;
      2'd2:    return ADDR_VCCAUX;
      default: return ADDR_VBRAM;
    endcase
  endfunction

  function automatic logic [SAMPLE_W-1:0] sample_of(input logic [DATA_W-1:0] d);
    return d[DATA_W-1 -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/xadc_poll_timer.sv
// Free-running sweep interval timer: counts down while poll_en is high,
// reloads at zero and emits a one-cycle sweep_due pulse.
module xadc_poll_timer #(
  parameter int pPOLL_INTERVAL = 50000
) (
  input  logic clk_usb,
  input  logic reset_n,
  input  logic poll_en,
  output logic sweep_due
);

  localparam int CNT_W = (pPOLL_INTERVAL > 1) ? $clog2(pPOLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(pPOLL_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             due_q, due_d;

  // NOTE: every _d gets a default before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    due_d = 1'b0;
    if (poll_en) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD;
        due_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RELOAD;
      due_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      due_q <= due_d;
    end
  end

  assign sweep_due = due_q;

endmodule

// File: rtl/xadc_drp_poller.sv
// Owns the XADC DRP port: arbitrates host accesses against a periodic sensor
// sweep, enforces a drdy timeout and caches the latest sensor readings.
module xadc_drp_poller
  import xadc_pkg::*;
#(
  parameter int pPOLL_INTERVAL = 50000,
  parameter int pTIMEOUT       = 255
) (
  input  logic                clk_usb,
  input  logic                reset_n,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_din,
  output logic                host_busy,
  output logic                host_done,
  output logic [DATA_W-1:0]   host_dout,
  input  logic                poll_en,
  input  logic                stat_clear,
  output logic [ADDR_W-1:0]   drp_addr,
  output logic                drp_den,
  output logic                drp_dwe,
  output logic [DATA_W-1:0]   drp_din,
  input  logic [DATA_W-1:0]   drp_dout,
  input  logic                drp_drdy,
  output logic [SAMPLE_W-1:0] temp_cur,
  output logic [SAMPLE_W-1:0] vccint_cur,
  output logic [SAMPLE_W-1:0] vccaux_cur,
  output logic [SAMPLE_W-1:0] vbram_cur,
  output logic [SAMPLE_W-1:0] temp_max,
  output logic                sample_valid,
  output logic                timeout_err
);

  localparam logic [7:0] TMO_LAST = 8'(pTIMEOUT - 1);

  // Reset asserts immediately but releases two clocks later, in this domain.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  logic sweep_due;

  xadc_poll_timer #(.pPOLL_INTERVAL(pPOLL_INTERVAL)) u_timer (
    .clk_usb  (clk_usb),
    .reset_n  (rst_n_int),
    .poll_en  (poll_en),
    .sweep_due(sweep_due)
  );

  state_e              state_q, state_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic                pend_q, pend_d, busy_q, busy_d, cur_host_q, cur_host_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d, drp_addr_q, drp_addr_d;
  logic [DATA_W-1:0]   req_din_q, req_din_d, drp_din_q, drp_din_d;
  logic [DATA_W-1:0]   host_dout_q, host_dout_d;
  logic                drp_den_q, drp_den_d, drp_dwe_q, drp_dwe_d;
  logic                host_done_q, host_done_d;
  logic                sweep_act_q, sweep_act_d, sweep_ok_q, sweep_ok_d;
  sweep_idx_t          sweep_idx_q, sweep_idx_d;
  logic [SAMPLE_W-1:0] temp_q, temp_d, vccint_q, vccint_d, vccaux_q, vccaux_d;
  logic [SAMPLE_W-1:0] vbram_q, vbram_d, temp_max_q, temp_max_d;
  logic                sample_valid_q, sample_valid_d, timeout_err_q, timeout_err_d;
  logic                finish, aborted;
  logic [SAMPLE_W-1:0] sample;

  assign sample  = sample_of(drp_dout);
  assign finish  = (state_q == ST_WAIT) && (drp_drdy || tcnt_q == TMO_LAST);
  assign aborted = finish && !drp_drdy;

  always_comb begin
    state_d = state_q;  tcnt_d = tcnt_q;
    pend_d = pend_q;  busy_d = busy_q;  cur_host_d = cur_host_q;
    req_we_d = req_we_q;  req_addr_d = req_addr_q;  req_din_d = req_din_q;
    drp_addr_d = drp_addr_q;  drp_din_d = drp_din_q;
    drp_den_d = 1'b0;  drp_dwe_d = 1'b0;  host_done_d = 1'b0;
    host_dout_d = host_dout_q;
    sweep_act_d = sweep_act_q;  sweep_ok_d = sweep_ok_q;  sweep_idx_d = sweep_idx_q;
    temp_d = temp_q;  vccint_d = vccint_q;  vccaux_d = vccaux_q;  vbram_d = vbram_q;
    temp_max_d = temp_max_q;  sample_valid_d = sample_valid_q;
    timeout_err_d = timeout_err_q;

    if (host_req && !busy_q) begin
      pend_d = 1'b1;  busy_d = 1'b1;
      req_we_d = host_we;  req_addr_d = host_addr;  req_din_d = host_din;
    end
    // A due pulse during an active sweep is dropped, not queued.
    if (sweep_due && !sweep_act_q) begin
      sweep_act_d = 1'b1;  sweep_idx_d = '0;  sweep_ok_d = 1'b1;
    end
    if (stat_clear) begin
      timeout_err_d = 1'b0;  temp_max_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_ISSUE;  pend_d = 1'b0;  cur_host_d = 1'b1;
          drp_den_d = 1'b1;  drp_dwe_d = req_we_q;
          drp_addr_d = req_addr_q;  drp_din_d = req_din_q;
        end else if (sweep_act_q) begin
          state_d = ST_ISSUE;  cur_host_d = 1'b0;
          drp_den_d = 1'b1;  drp_addr_d = sweep_addr(sweep_idx_q);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;  tcnt_d = '0;
      end
      ST_WAIT: begin
        if (!finish) tcnt_d = tcnt_q + 8'd1;
        else         state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Results land on the WAIT->DONE edge so they are visible during DONE.
    if (finish) begin
      if (aborted) timeout_err_d = 1'b1;
      if (cur_host_q) begin
        host_done_d = 1'b1;  busy_d = 1'b0;
        if (aborted)        host_dout_d = 16'hFFFF;
        else if (!req_we_q) host_dout_d = drp_dout;
      end else begin
        if (!aborted) begin
          case (sweep_idx_q)
            2'd0: begin
              temp_d = sample;
              if (stat_clear || sample > temp_max_q) temp_max_d = sample;
            end
            2'd1:    vccint_d = sample;
            2'd2:    vccaux_d = sample;
            default: vbram_d  = sample;
          endcase
        end
        if (aborted) sweep_ok_d = 1'b0;
        if (sweep_idx_q == sweep_idx_t'(SWEEP_LEN - 1)) begin
          sweep_act_d = 1'b0;
          if (sweep_ok_q && !aborted) sample_valid_d = 1'b1;
        end else begin
          sweep_idx_d = sweep_idx_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_usb or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;  tcnt_q <= '0;
      pend_q <= 1'b0;  busy_q <= 1'b0;  cur_host_q <= 1'b0;
      req_we_q <= 1'b0;  req_addr_q <= '0;  req_din_q <= '0;
      drp_addr_q <= '0;  drp_din_q <= '0;  drp_den_q <= 1'b0;  drp_dwe_q <= 1'b0;
      host_done_q <= 1'b0;  host_dout_q <= '0;
      sweep_act_q <= 1'b0;  sweep_ok_q <= 1'b0;  sweep_idx_q <= '0;
      temp_q <= '0;  vccint_q <= '0;  vccaux_q <= '0;  vbram_q <= '0;
      temp_max_q <= '0;  sample_valid_q <= 1'b0;  timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;  tcnt_q <= tcnt_d;
      pend_q <= pend_d;  busy_q <= busy_d;  cur_host_q <= cur_host_d;
      req_we_q <= req_we_d;  req_addr_q <= req_addr_d;  req_din_q <= req_din_d;
      drp_addr_q <= drp_addr_d;  drp_din_q <= drp_din_d;
      drp_den_q <= drp_den_d;  drp_dwe_q <= drp_dwe_d;
      host_done_q <= host_done_d;  host_dout_q <= host_dout_d;
      sweep_act_q <= sweep_act_d;  sweep_ok_q <= sweep_ok_d;  sweep_idx_q <= sweep_idx_d;
      temp_q <= temp_d;  vccint_q <= vccint_d;  vccaux_q <= vccaux_d;  vbram_q <= vbram_d;
      temp_max_q <= temp_max_d;  sample_valid_q <= sample_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign host_busy    = busy_q;
  assign host_done    = host_done_q;
  assign host_dout    = host_dout_q;
  assign drp_addr     = drp_addr_q;
  assign drp_den      = drp_den_q;
  assign drp_dwe      = drp_dwe_q;
  assign drp_din      = drp_din_q;
  assign temp_cur     = temp_q;
  assign vccint_cur   = vccint_q;
  assign vccaux_cur   = vccaux_q;
  assign vbram_cur    = vbram_q;
  assign temp_max     = temp_max_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_xadc_drp_poller.sv
// Testbench for xadc_drp_poller: a behavioural XADC register file answers DRP
// accesses; expected results and timing come from the bench's own model.
module tb_xadc_drp_poller;

  localparam int P_POLL = 16;
  localparam int P_TMO  = 10;

  logic        clk_usb = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_din = '0;
  logic        poll_en = 1'b0, stat_clear_t = 1'b0, stat_clear_s = 1'b0, stat_clear;
  logic [15:0] drp_dout = '0;
  logic        drp_drdy = 1'b0;
  logic        host_busy, host_done, drp_den, drp_dwe, sample_valid, timeout_err;
  logic [15:0] host_dout, drp_din;
  logic [6:0]  drp_addr;
  logic [11:0] temp_cur, vccint_cur, vccaux_cur, vbram_cur, temp_max;

  assign stat_clear = stat_clear_t | stat_clear_s;

  xadc_drp_poller #(.pPOLL_INTERVAL(P_POLL), .pTIMEOUT(P_TMO)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_busy(host_busy), .host_done(host_done), .host_dout(host_dout),
    .poll_en(poll_en), .stat_clear(stat_clear),
    .drp_addr(drp_addr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_din(drp_din),
    .drp_dout(drp_dout), .drp_drdy(drp_drdy),
    .temp_cur(temp_cur), .vccint_cur(vccint_cur), .vccaux_cur(vccaux_cur),
    .vbram_cur(vbram_cur), .temp_max(temp_max),
    .sample_valid(sample_valid), .timeout_err(timeout_err)
  );

  always #5 clk_usb = ~clk_usb;

  int cyc = 0;
  always @(posedge clk_usb) cyc <= cyc + 1;

  wire [104:0] all_outs = {host_busy, host_done, host_dout, drp_addr, drp_den, drp_dwe,
                           drp_din, temp_cur, vccint_cur, vccaux_cur, vbram_cur,
                           temp_max, sample_valid, timeout_err};

  // Behavioural XADC: register array, per-address silence, programmable latency.
  typedef struct { int cyc; logic [6:0] addr; logic we; logic [15:0] din; } den_t;
  den_t        dlog[$];
  logic [15:0] mem [128];
  bit          mute [128];
  int          delay = 3;
  bit          clr_with_temp = 1'b0;
  logic [6:0]  s_addr;
  logic [6:0]  sweep_a [4] = '{7'h00, 7'h01, 7'h02, 7'h06};

  initial begin
    forever begin
      @(posedge clk_usb); #1;
      if (drp_den === 1'b1) begin
        s_addr = drp_addr;
        dlog.push_back('{cyc, drp_addr, drp_dwe, drp_din});
        if (drp_dwe === 1'b1) mem[s_addr] = drp_din;
        if (!mute[s_addr]) begin
          repeat (delay) @(posedge clk_usb);
          #1;
          drp_drdy = 1'b1;
          drp_dout = mem[s_addr];
          if (clr_with_temp && s_addr == 7'h00) stat_clear_s = 1'b1;
          @(posedge clk_usb); #1;
          drp_drdy = 1'b0;
          stat_clear_s = 1'b0;
          drp_dout = 16'($urandom);
        end
      end
    end
  end

  int          done_cnt = 0, done_cyc = 0;
  logic [15:0] done_dout = '0;
  logic        done_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk_usb); #2;
      if (host_done === 1'b1) begin
        done_cnt++; done_cyc = cyc; done_dout = host_dout; done_busy = host_busy;
      end
    end
  end

  int          n_tests = 0, n_fail = 0;
  logic [11:0] exp_max = '0;
  logic [15:0] exp_host_dout = '0;

  task automatic tick();
    @(posedge clk_usb); #3;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; host_req = 1'b0; poll_en = 1'b0; stat_clear_t = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    exp_max = '0; exp_host_dout = '0;
  endtask

  task automatic host_op(input logic we, input logic [6:0] a, input logic [15:0] d,
                         output int req_cyc);
    for (int n = 0; n < 100 && host_busy === 1'b1; n++) tick();
    host_req = 1'b1; host_we = we; host_addr = a; host_din = d;
    req_cyc = cyc;
    tick();
    host_req = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done_cnt > start) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic pulse_clear();
    stat_clear_t = 1'b1; tick(); stat_clear_t = 1'b0;
  endtask

  task automatic run_sweep(output int ndens);
    dlog.delete();
    poll_en = 1'b1;
    for (int i = 0; i < 300 && dlog.size() < 4; i++) tick();
    poll_en = 1'b0;
    repeat (20) tick();
    ndens = dlog.size();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++; if (all_outs !== '0) begin n_fail++; $display("FAIL reset_hold outs=%h want 0", all_outs); end
    reset_n = 1'b1;
    repeat (6) tick();
    n_tests++; if (all_outs !== '0) begin n_fail++; $display("FAIL reset_idle outs=%h want 0", all_outs); end
  endtask

  task automatic test_host_read();
    int rc, d, start; bit seen; logic [6:0] a; logic [15:0] v;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin a = 7'h01; v = 16'h5A50; d = 3; end
      else begin a = 7'($urandom_range(8, 127)); v = 16'($urandom); d = int'($urandom_range(1, 6)); end
      mem[a] = v; delay = d; dlog.delete(); start = done_cnt;
      host_op(1'b0, a, 16'($urandom), rc);
      n_tests++; if (host_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy got %b want 1", host_busy); end
      wait_done(start, 40, seen);
      n_tests++; if (!seen) begin n_fail++; $display("FAIL rd_done_seen got 0 want 1"); end
      n_tests++;
      if (dlog.size() != 1) begin n_fail++; $display("FAIL rd_den_count got %0d want 1", dlog.size()); end
      else begin
        n_tests++; if (dlog[0].cyc != rc + 2) begin n_fail++; $display("FAIL rd_den_lat got %0d want %0d", dlog[0].cyc, rc + 2); end
        n_tests++; if ({dlog[0].we, dlog[0].addr} !== {1'b0, a}) begin n_fail++; $display("FAIL rd_den_fields got %b/%h want 0/%h", dlog[0].we, dlog[0].addr, a); end
      end
      n_tests++; if (done_cyc != rc + 3 + d) begin n_fail++; $display("FAIL rd_done_lat got %0d want %0d", done_cyc, rc + 3 + d); end
      n_tests++; if (done_dout !== v) begin n_fail++; $display("FAIL rd_dout got %h want %h", done_dout, v); end
      n_tests++; if (done_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_fall got %b want 0", done_busy); end
      exp_host_dout = v;
      repeat (2) tick();
      n_tests++; if (host_dout !== exp_host_dout) begin n_fail++; $display("FAIL rd_dout_hold got %h want %h", host_dout, exp_host_dout); end
    end
  endtask

  task automatic test_host_write();
    int rc, start; bit seen; logic [6:0] a; logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin a = 7'h41; v = 16'h1234; end
      else begin a = 7'($urandom_range(8, 127)); v = 16'($urandom); end
      delay = int'($urandom_range(1, 4)); dlog.delete(); start = done_cnt;
      host_op(1'b1, a, v, rc);
      wait_done(start, 40, seen);
      n_tests++; if (!seen) begin n_fail++; $display("FAIL wr_done_seen got 0 want 1"); end
      n_tests++;
      if (dlog.size() != 1) begin n_fail++; $display("FAIL wr_den_count got %0d want 1", dlog.size()); end
      else begin
        n_tests++; if ({dlog[0].we, dlog[0].addr, dlog[0].din} !== {1'b1, a, v}) begin n_fail++; $display("FAIL wr_den_fields got %b/%h/%h want 1/%h/%h", dlog[0].we, dlog[0].addr, dlog[0].din, a, v); end
        n_tests++; if (dlog[0].cyc != rc + 2) begin n_fail++; $display("FAIL wr_den_lat got %0d want %0d", dlog[0].cyc, rc + 2); end
      end
      n_tests++; if (done_dout !== exp_host_dout) begin n_fail++; $display("FAIL wr_dout_kept got %h want %h", done_dout, exp_host_dout); end
      tick();
    end
  endtask

  task automatic test_sweep();
    int nd;
    mem[0] = {12'h9A0, 4'h0};
    for (int k = 1; k < 4; k++) mem[sweep_a[k]] = 16'($urandom);
    delay = int'($urandom_range(1, 4));
    run_sweep(nd);
    n_tests++;
    if (nd != 4) begin n_fail++; $display("FAIL sw_den_count got %0d want 4", nd); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++; if ({dlog[k].we, dlog[k].addr} !== {1'b0, sweep_a[k]}) begin n_fail++; $display("FAIL sw_order[%0d] got %b/%h want 0/%h", k, dlog[k].we, dlog[k].addr, sweep_a[k]); end
      end
    end
    exp_max = (12'h9A0 > exp_max) ? 12'h9A0 : exp_max;
    n_tests++; if (temp_cur !== 12'h9A0) begin n_fail++; $display("FAIL sw_temp got %h want 9a0", temp_cur); end
    n_tests++; if ({vccint_cur, vccaux_cur, vbram_cur} !== {mem[1][15:4], mem[2][15:4], mem[6][15:4]}) begin n_fail++; $display("FAIL sw_rails got %h/%h/%h want %h/%h/%h", vccint_cur, vccaux_cur, vbram_cur, mem[1][15:4], mem[2][15:4], mem[6][15:4]); end
    n_tests++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL sw_valid got %b want 1", sample_valid); end
    n_tests++; if (temp_max !== exp_max) begin n_fail++; $display("FAIL sw_max got %h want %h", temp_max, exp_max); end
  endtask

  task automatic test_temp_max();
    int nd; logic [11:0] t;
    logic [11:0] seq [3] = '{12'h800, 12'h700, 12'h650};
    pulse_clear(); exp_max = '0;
    n_tests++; if (temp_max !== 12'h000) begin n_fail++; $display("FAIL max_clear0 got %h want 000", temp_max); end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        pulse_clear(); exp_max = '0;
        n_tests++; if (temp_max !== 12'h000) begin n_fail++; $display("FAIL max_clear got %h want 000", temp_max); end
      end
      t = (i < 3) ? seq[i] : 12'($urandom);
      mem[0] = {t, 4'($urandom)};
      delay = int'($urandom_range(1, 4));
      run_sweep(nd);
      exp_max = (t > exp_max) ? t : exp_max;
      n_tests++; if (temp_max !== exp_max) begin n_fail++; $display("FAIL max_seq[%0d] got %h want %h", i, temp_max, exp_max); end
    end
    t = exp_max >> 1;
    mem[0] = {t, 4'h0};
    clr_with_temp = 1'b1;
    run_sweep(nd);
    clr_with_temp = 1'b0;
    exp_max = t;
    n_tests++; if (temp_max !== exp_max) begin n_fail++; $display("FAIL max_clear_coinc got %h want %h", temp_max, exp_max); end
  endtask

  task automatic test_timeout();
    int rc, start, nd; bit seen;
    mute[7'h20] = 1'b1; dlog.delete(); start = done_cnt;
    host_op(1'b0, 7'h20, 16'h0, rc);
    wait_done(start, 40, seen);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL to_done_seen got 0 want 1"); end
    n_tests++; if (done_cyc != rc + 2 + P_TMO + 1) begin n_fail++; $display("FAIL to_done_lat got %0d want %0d", done_cyc, rc + 3 + P_TMO); end
    n_tests++; if (done_dout !== 16'hFFFF) begin n_fail++; $display("FAIL to_dout got %h want ffff", done_dout); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set got %b want 1", timeout_err); end
    mute[7'h20] = 1'b0;
    tick();
    pulse_clear();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %b want 0", timeout_err); end
    do_reset();
    mem[0] = 16'($urandom) | 16'h0010; mem[1] = 16'($urandom);
    mute[0] = 1'b1; delay = 2;
    run_sweep(nd);
    n_tests++; if (nd != 4) begin n_fail++; $display("FAIL to_sw_count got %0d want 4", nd); end
    n_tests++; if ({temp_cur, vccint_cur} !== {12'h000, mem[1][15:4]}) begin n_fail++; $display("FAIL to_sw_cur got %h/%h want 000/%h", temp_cur, vccint_cur, mem[1][15:4]); end
    n_tests++; if ({sample_valid, timeout_err} !== 2'b01) begin n_fail++; $display("FAIL to_sw_flags got %b want 01", {sample_valid, timeout_err}); end
    mute[0] = 1'b0;
    run_sweep(nd);
    exp_max = mem[0][15:4];
    n_tests++; if ({sample_valid, temp_cur, temp_max} !== {1'b1, mem[0][15:4], exp_max}) begin n_fail++; $display("FAIL to_sw_recover got %b/%h/%h want 1/%h/%h", sample_valid, temp_cur, temp_max, mem[0][15:4], exp_max); end
  endtask

  task automatic test_back_to_back();
    int start; logic [6:0] ha, hb; logic [6:0] want [5];
    ha = 7'($urandom_range(8, 63)); hb = 7'($urandom_range(64, 127));
    mem[ha] = 16'($urandom); delay = int'($urandom_range(2, 4));
    dlog.delete(); start = done_cnt;
    poll_en = 1'b1;
    for (int i = 0; i < 300 && dlog.size() < 1; i++) tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = ha;
    tick();
    n_tests++; if (host_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", host_busy); end
    host_we = 1'b1; host_addr = hb; host_din = 16'($urandom);
    tick();
    host_req = 1'b0;
    for (int i = 0; i < 300 && dlog.size() < 5; i++) tick();
    poll_en = 1'b0;
    repeat (20) tick();
    want = '{7'h00, ha, 7'h01, 7'h02, 7'h06};
    n_tests++;
    if (dlog.size() != 5) begin n_fail++; $display("FAIL b2b_den_count got %0d want 5", dlog.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++; if ({dlog[k].we, dlog[k].addr} !== {1'b0, want[k]}) begin n_fail++; $display("FAIL b2b_order[%0d] got %b/%h want 0/%h", k, dlog[k].we, dlog[k].addr, want[k]); end
      end
    end
    n_tests++; if (done_cnt - start != 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - start); end
    n_tests++; if (done_dout !== mem[ha]) begin n_fail++; $display("FAIL b2b_dout got %h want %h", done_dout, mem[ha]); end
  endtask

  task automatic test_reset_mid();
    int rc, start;
    mem[7'h30] = 16'($urandom); delay = 6; dlog.delete(); start = done_cnt;
    host_op(1'b0, 7'h30, 16'h0, rc);
    for (int i = 0; i < 10 && dlog.size() < 1; i++) tick();
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    n_tests++; if (all_outs !== '0) begin n_fail++; $display("FAIL rstmid_outs got %h want 0", all_outs); end
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    n_tests++; if (done_cnt != start) begin n_fail++; $display("FAIL rstmid_late_drdy done got %0d want %0d", done_cnt, start); end
    n_tests++; if (all_outs !== '0) begin n_fail++; $display("FAIL rstmid_after got %h want 0", all_outs); end
    n_tests++; if (dlog.size() != 1) begin n_fail++; $display("FAIL rstmid_reissue got %0d want 1", dlog.size()); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin mem[i] = 16'($urandom); mute[i] = 1'b0; end
    test_reset();
    test_host_read();
    test_host_write();
    test_sweep();
    test_temp_max();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
